id_stage_pipe: RTL
==================

# id_stage_pipe

Pipelined, parametrised instruction-decode stage for the RV32I core. It decodes the instruction, reads an NREGS×XLEN register file and generates the sign-extended immediate and main-control signals. Results are captured in an ID/EX pipeline register with valid/ready handshakes on both sides. The block sits between the fetch stage and the execute stage, stalls on load-use hazards, flushes on redirect, and takes the writeback port from the WB stage.

## Interface
- XLEN, 32: datapath width (32 or 64); instruction width fixed at 32
- NREGS, 32: architectural registers (32 = RV32I, 16 = RV32E); REG_AW = $clog2(NREGS) derived
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- if_valid  in  1  instruction offered by fetch
- if_instr  in  32  instruction word
- id_ready  out  1  stage accepts if_instr this cycle
- flush  in  1  discard ID/EX contents and refuse input this cycle
- wb_we  in  1  register write enable
- wb_rd  in  5  write index
- wb_data  in  XLEN  write data
- ex_ready  in  1  execute consumes ID/EX this cycle
- ex_valid  out  1  ID/EX holds a valid instruction
- ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  operands and immediate
- ex_rs1, ex_rs2, ex_rd  out  5  register indices (for EX forwarding)
- ex_opcode  out  7; ex_fn3  out  3; ex_fn7_5  out  1
- ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_alu_src, ex_reg_write  out  1
- ex_memtoreg  out  2  00 ALU, 01 memory, 10 PC+4
- ex_aluop  out  3  000 add, 001 branch-compare, 010 R-type, 011 I-type ALU, 100 pass-imm (LUI)
- ex_illegal  out  1  unsupported opcode or out-of-range register index

## Operation
- Decoding is combinational from if_instr.
- Supported opcodes: LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111, BRANCH 1100011, LOAD 0000011, STORE 0100011, OP-IMM 0010011, OP 0110011.
- Any other opcode: illegal=1, all control outputs 0.
- Immediate formats I/S/B/U/J, sign-extended from instr[31] to XLEN. B and J immediates have bit 0 = 0.
- Register index ≥ NREGS (only possible with NREGS=16): illegal=1, reg_write forced 0.
- Register file: reading x0 returns 0. A write takes effect at the rising edge when wb_we && wb_rd!=0 && wb_rd<NREGS.
- Load-use hazard: ex_valid && ex_mem_read && ex_rd!=0 && (ex_rd==rs1 used || ex_rd==rs2 used).
  - Usage: rs1 is used by all formats except U/J. rs2 is used by R/S/B only.
- id_ready = reset-released && !flush && !hazard && (!ex_valid || ex_ready).
- Register update priority: flush > transfer > bubble > hold.
  - flush: ex_valid←0.
  - Transfer (if_valid && id_ready): all ex_* ← decoded values, ex_valid←1.
  - Bubble (hazard && ex_ready, or !if_valid && ex_ready): ex_valid←0, control bits ←0.
  - Hold: ex_valid && !ex_ready; every ex_* output stays stable.
- Illegal instructions still transfer with ex_illegal=1 and all control bits 0. Trap handling belongs to EX.

## Timing
- Reset: ex_valid=0; all ex_* outputs 0; all registers 0. id_ready=0 while reset is asserted.
- Reset mid-stall or mid-hold: asserting reset clears everything immediately, with no pending transfer retained.
- Latency is 1 cycle: an instruction accepted at edge N appears on ex_* after edge N.
- Load-use inserts exactly one bubble: the load leaves ID/EX, a bubble follows, then the dependent instruction is accepted the next cycle.
- flush concurrent with if_valid: the instruction is not accepted (id_ready=0). flush concurrent with hold: the held contents are discarded.
- A writeback at the same edge as a transfer reading the same register: see Configuration.

## Configuration
- ID_WB_BYPASS_EN defined: operand capture selects wb_data when wb_we && wb_rd==rs && rs!=0, so a same-cycle writeback is seen (write-first).
- Not defined: operand capture uses the array content before the write (read-first). The core must then space the dependent instruction by one cycle; the hazard logic does not cover this case.

## Test plan
- Reset, then send `addi x1,x0,-5` (0xFFB00093) → next cycle ex_valid=1, ex_imm=0xFFFFFFFB, ex_aluop=011, ex_alu_src=1, ex_reg_write=1, ex_rd=1.
- wb_we=1, wb_rd=5, wb_data=0x1234 on the same edge as `add x6,x5,x0` is accepted → ex_rs1_data=0x1234 with ID_WB_BYPASS_EN; 0 without it.
- Send `lw x2,0(x1)`, then `add x3,x2,x2` with ex_ready=1 → id_ready=0 for 1 cycle, one ex_valid=0 bubble, then the add is accepted.
- ex_ready=0 for 3 cycles while ex_valid=1 → all ex_* outputs are unchanged and id_ready=0. Release → the next instruction transfers.
- Opcode 0x0000007F, or NREGS=16 with rd=x20 → ex_illegal=1 and ex_reg_write=0. Write to x0 → x0 still reads 0.
- flush asserted while holding and while if_valid=1 → ex_valid=0 next cycle and the offered instruction is not accepted. Asynchronous reset mid-hold → outputs clear immediately.

Source files
------------

// File: rtl/id_stage_pipe_if.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe_if
// Purpose  : Fetch, writeback and ID/EX handshake bundle for id_stage_pipe.
// Revision : 1.0
// ============================================================================
interface id_stage_pipe_if #(
   parameter int XLEN = 32
);
   logic            if_valid;
   logic [31:0]     if_instr;
   logic            id_ready;
   logic            flush;
   logic            wb_we;
   logic [4:0]      wb_rd;
   logic [XLEN-1:0] wb_data;
   logic            ex_ready;
   logic            ex_valid;
   logic [XLEN-1:0] ex_rs1_data;
   logic [XLEN-1:0] ex_rs2_data;
   logic [XLEN-1:0] ex_imm;
   logic [4:0]      ex_rs1;
   logic [4:0]      ex_rs2;
   logic [4:0]      ex_rd;
   logic [6:0]      ex_opcode;
   logic [2:0]      ex_fn3;
   logic            ex_fn7_5;
   logic            ex_branch;
   logic            ex_jump;
   logic            ex_mem_read;
   logic            ex_mem_write;
   logic            ex_alu_src;
   logic            ex_reg_write;
   logic [1:0]      ex_memtoreg;
   logic [2:0]      ex_aluop;
   logic            ex_illegal;

   modport master (
      output if_valid, if_instr, flush, wb_we, wb_rd, wb_data, ex_ready,
      input  id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_fn3, ex_fn7_5,
             ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_alu_src,
             ex_reg_write, ex_memtoreg, ex_aluop, ex_illegal
   );

   modport slave (
      input  if_valid, if_instr, flush, wb_we, wb_rd, wb_data, ex_ready,
      output id_ready, ex_valid, ex_rs1_data, ex_rs2_data, ex_imm,
             ex_rs1, ex_rs2, ex_rd, ex_opcode, ex_fn3, ex_fn7_5,
             ex_branch, ex_jump, ex_mem_read, ex_mem_write, ex_alu_src,
             ex_reg_write, ex_memtoreg, ex_aluop, ex_illegal
   );
endinterface
`default_nettype wire

// File: rtl/id_stage_pipe.sv
`default_nettype none
// ============================================================================
// Module   : id_stage_pipe
// Purpose  : RV32I decode, NREGS x XLEN register file and ID/EX register with
//            load-use stall. Define ID_WB_BYPASS_EN for write-first capture.
// Revision : 1.0
// ============================================================================
module id_stage_pipe #(
   parameter int XLEN  = 32,
   parameter int NREGS = 32
) (
   input  wire logic      clk,
   input  wire logic      rst_n,
   id_stage_pipe_if.slave bus
);
   localparam int REG_AW = $clog2(NREGS);

   localparam logic [6:0] c_OP_LUI    = 7'b0110111;
   localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] c_OP_JAL    = 7'b1101111;
   localparam logic [6:0] c_OP_JALR   = 7'b1100111;
   localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
   localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
   localparam logic [6:0] c_OP_STORE  = 7'b0100011;
   localparam logic [6:0] c_OP_IMM    = 7'b0010011;
   localparam logic [6:0] c_OP_OP     = 7'b0110011;

   typedef struct packed {
      logic       branch;
      logic       jump;
      logic       mem_read;
      logic       mem_write;
      logic       alu_src;
      logic       reg_write;
      logic [1:0] memtoreg;
      logic [2:0] aluop;
   } ctrl_t;

   logic [31:0]     w_instr;
   logic [6:0]      w_opcode;
   logic [4:0]      w_rd;
   logic [4:0]      w_rs1;
   logic [4:0]      w_rs2;
   logic [XLEN-1:0] w_imm_i;
   logic [XLEN-1:0] w_imm_s;
   logic [XLEN-1:0] w_imm_b;
   logic [XLEN-1:0] w_imm_u;
   logic [XLEN-1:0] w_imm_j;
   logic [XLEN-1:0] w_imm;
   ctrl_t           w_dec;
   ctrl_t           w_ctl;
   logic            w_known;
   logic            w_use_rs1;
   logic            w_use_rs2;
   logic            w_reg_oob;
   logic            w_wb_in_range;
   logic            w_wb_wr;
   logic            w_illegal;
   logic            w_hazard;
   logic            w_id_ready;
   logic            w_xfer;
   logic            w_bubble;
   logic [XLEN-1:0] w_rs1_rf;
   logic [XLEN-1:0] w_rs2_rf;
   logic [XLEN-1:0] w_rs1_data;
   logic [XLEN-1:0] w_rs2_data;

   logic [XLEN-1:0] r_rf [NREGS];
   logic            r_ex_valid;
   ctrl_t           r_ctl;
   logic            r_illegal;
   logic [XLEN-1:0] r_rs1_data;
   logic [XLEN-1:0] r_rs2_data;
   logic [XLEN-1:0] r_imm;
   logic [4:0]      r_rs1;
   logic [4:0]      r_rs2;
   logic [4:0]      r_rd;
   logic [6:0]      r_opcode;
   logic [2:0]      r_fn3;
   logic            r_fn7_5;

   assign w_instr  = bus.if_instr;
   assign w_opcode = w_instr[6:0];
   assign w_rd     = w_instr[11:7];
   assign w_rs1    = w_instr[19:15];
   assign w_rs2    = w_instr[24:20];

   assign w_imm_i = XLEN'($signed(w_instr[31:20]));
   assign w_imm_s = XLEN'($signed({w_instr[31:25], w_instr[11:7]}));
   assign w_imm_b = XLEN'($signed({w_instr[31], w_instr[7], w_instr[30:25], w_instr[11:8], 1'b0}));
   assign w_imm_u = XLEN'($signed({w_instr[31:12], 12'h000}));
   assign w_imm_j = XLEN'($signed({w_instr[31], w_instr[19:12], w_instr[20], w_instr[30:21], 1'b0}));

   always_comb begin
      w_dec     = '0;
      w_known   = 1'b1;
      w_use_rs1 = 1'b0;
      w_use_rs2 = 1'b0;
      w_imm     = '0;
      case (w_opcode)
         c_OP_LUI: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.aluop     = 3'b100;
            w_imm           = w_imm_u;
         end
         c_OP_AUIPC: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_imm           = w_imm_u;
         end
         c_OP_JAL: begin
            w_dec.jump      = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.memtoreg  = 2'b10;
            w_imm           = w_imm_j;
         end
         c_OP_JALR: begin
            w_dec.jump      = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.memtoreg  = 2'b10;
            w_use_rs1       = 1'b1;
            w_imm           = w_imm_i;
         end
         c_OP_BRANCH: begin
            w_dec.branch    = 1'b1;
            w_dec.aluop     = 3'b001;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
            w_imm           = w_imm_b;
         end
         c_OP_LOAD: begin
            w_dec.mem_read  = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.memtoreg  = 2'b01;
            w_use_rs1       = 1'b1;
            w_imm           = w_imm_i;
         end
         c_OP_STORE: begin
            w_dec.mem_write = 1'b1;
            w_dec.alu_src   = 1'b1;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
            w_imm           = w_imm_s;
         end
         c_OP_IMM: begin
            w_dec.alu_src   = 1'b1;
            w_dec.reg_write = 1'b1;
            w_dec.aluop     = 3'b011;
            w_use_rs1       = 1'b1;
            w_imm           = w_imm_i;
         end
         c_OP_OP: begin
            w_dec.reg_write = 1'b1;
            w_dec.aluop     = 3'b010;
            w_use_rs1       = 1'b1;
            w_use_rs2       = 1'b1;
         end
         default: w_known = 1'b0;
      endcase
   end

   // A 5-bit index can only exceed the file when NREGS is below 32 (RV32E)
   generate
      if (NREGS < 32) begin : g_reg_range
         assign w_reg_oob = (w_dec.reg_write && (w_rd  >= 5'(NREGS)))
                          || (w_use_rs1      && (w_rs1 >= 5'(NREGS)))
                          || (w_use_rs2      && (w_rs2 >= 5'(NREGS)));
         assign w_wb_in_range = (bus.wb_rd < 5'(NREGS));
      end else begin : g_reg_full
         assign w_reg_oob     = 1'b0;
         assign w_wb_in_range = 1'b1;
      end
   endgenerate

   assign w_illegal = !w_known || w_reg_oob;
   assign w_ctl     = w_illegal ? '0 : w_dec;
   assign w_wb_wr   = bus.wb_we && (bus.wb_rd != 5'd0) && w_wb_in_range;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            r_rf[i] <= '0;
         end
      end else if (w_wb_wr) begin
         r_rf[bus.wb_rd[REG_AW-1:0]] <= bus.wb_data;
      end
   end

   assign w_rs1_rf = (w_rs1 == 5'd0) ? '0 : r_rf[w_rs1[REG_AW-1:0]];
   assign w_rs2_rf = (w_rs2 == 5'd0) ? '0 : r_rf[w_rs2[REG_AW-1:0]];

`ifdef ID_WB_BYPASS_EN
   assign w_rs1_data = (bus.wb_we && (bus.wb_rd == w_rs1) && (w_rs1 != 5'd0)) ? bus.wb_data : w_rs1_rf;
   assign w_rs2_data = (bus.wb_we && (bus.wb_rd == w_rs2) && (w_rs2 != 5'd0)) ? bus.wb_data : w_rs2_rf;
`else
   assign w_rs1_data = w_rs1_rf;
   assign w_rs2_data = w_rs2_rf;
`endif

   assign w_hazard = r_ex_valid && r_ctl.mem_read && (r_rd != 5'd0)
                   && (((r_rd == w_rs1) && w_use_rs1) || ((r_rd == w_rs2) && w_use_rs2));

   assign w_id_ready = rst_n && !bus.flush && !w_hazard && (!r_ex_valid || bus.ex_ready);
   assign w_xfer     = bus.if_valid && w_id_ready;
   assign w_bubble   = bus.ex_ready && (w_hazard || !bus.if_valid);

   // Priority: flush, transfer, bubble, otherwise hold
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex_valid <= 1'b0;
         r_ctl      <= '0;
         r_illegal  <= 1'b0;
         r_rs1_data <= '0;
         r_rs2_data <= '0;
         r_imm      <= '0;
         r_rs1      <= '0;
         r_rs2      <= '0;
         r_rd       <= '0;
         r_opcode   <= '0;
         r_fn3      <= '0;
         r_fn7_5    <= 1'b0;
      end else if (bus.flush) begin
         r_ex_valid <= 1'b0;
         r_ctl      <= '0;
         r_illegal  <= 1'b0;
      end else if (w_xfer) begin
         r_ex_valid <= 1'b1;
         r_ctl      <= w_ctl;
         r_illegal  <= w_illegal;
         r_rs1_data <= w_rs1_data;
         r_rs2_data <= w_rs2_data;
         r_imm      <= w_imm;
         r_rs1      <= w_rs1;
         r_rs2      <= w_rs2;
         r_rd       <= w_rd;
         r_opcode   <= w_opcode;
         r_fn3      <= w_instr[14:12];
         r_fn7_5    <= w_instr[30];
      end else if (w_bubble) begin
         r_ex_valid <= 1'b0;
         r_ctl      <= '0;
         r_illegal  <= 1'b0;
      end
   end

   assign bus.id_ready     = w_id_ready;
   assign bus.ex_valid     = r_ex_valid;
   assign bus.ex_rs1_data  = r_rs1_data;
   assign bus.ex_rs2_data  = r_rs2_data;
   assign bus.ex_imm       = r_imm;
   assign bus.ex_rs1       = r_rs1;
   assign bus.ex_rs2       = r_rs2;
   assign bus.ex_rd        = r_rd;
   assign bus.ex_opcode    = r_opcode;
   assign bus.ex_fn3       = r_fn3;
   assign bus.ex_fn7_5     = r_fn7_5;
   assign bus.ex_branch    = r_ctl.branch;
   assign bus.ex_jump      = r_ctl.jump;
   assign bus.ex_mem_read  = r_ctl.mem_read;
   assign bus.ex_mem_write = r_ctl.mem_write;
   assign bus.ex_alu_src   = r_ctl.alu_src;
   assign bus.ex_reg_write = r_ctl.reg_write;
   assign bus.ex_memtoreg  = r_ctl.memtoreg;
   assign bus.ex_aluop     = r_ctl.aluop;
   assign bus.ex_illegal   = r_illegal;
endmodule
`default_nettype wire
